imem_loader: RTL and testbench

Program loader for the single-cycle RISC-V core's instruction memory. It accepts a length-prefixed byte stream over a valid/ready handshake and assembles the bytes into little-endian 32-bit instruction words. Each word is written into the byte-addressed instruction memory at address 4·index. The core is held in reset until the whole image is written.

---
 rtl/imem_loader.sv | 162 ++++++++++++++++
 tb/tb_imem_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Summary  : Length-prefixed byte-stream loader for the core's instruction
//            memory; holds the core in reset until the full image is written.
// Revision : 1.0
// ============================================================================
module imem_loader #(
    parameter int MAX_WORDS = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  inData,
    input  logic        inValid,
    output logic        inReady,
    output logic        writeEnable,
    output logic [31:0] writeAddress,
    output logic [31:0] writeData,
    output logic [15:0] wordsLoaded,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpuReset
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_FLUSH  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [16:0] C_MAX_WORDS = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] n_q, n_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [23:0] word_buf_q, word_buf_d;
    logic        we_q, we_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] loaded_q, loaded_d;

    logic        w_accept;
    logic [15:0] w_len;

    assign inReady  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
    assign busy     = inReady || (state_q == S_FLUSH);
    assign done     = (state_q == S_DONE);
    assign error    = (state_q == S_ERROR);
    assign cpuReset = (state_q != S_DONE);

    assign writeEnable  = we_q;
    assign writeAddress = waddr_q;
    assign writeData    = wdata_q;
    assign wordsLoaded  = loaded_q;

    assign w_accept = inValid && inReady;
    assign w_len    = {inData, len_lo_q};

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        n_d        = n_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        word_buf_d = word_buf_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        loaded_d   = loaded_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d  = S_LEN_LO;
                    loaded_d = 16'd0;
                end
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    len_lo_d = inData;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    n_d = w_len;
                    if ((w_len == 16'd0) || ({1'b0, w_len} > C_MAX_WORDS)) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d    = S_DATA;
                        byte_idx_d = 2'd0;
                        word_idx_d = 16'd0;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_buf_d[7:0]   = inData;
                        2'd1: word_buf_d[15:8]  = inData;
                        2'd2: word_buf_d[23:16] = inData;
                        default: begin
                            // Last byte of the word: register the strobe so the
                            // stream keeps flowing while memory commits.
                            we_d       = 1'b1;
                            waddr_d    = {14'd0, word_idx_q, 2'b00};
                            wdata_d    = {inData, word_buf_q};
                            loaded_d   = loaded_q + 16'd1;
                            word_idx_d = word_idx_q + 16'd1;
                            if (word_idx_q == (n_q - 16'd1)) begin
                                state_d = S_FLUSH;
                            end
                        end
                    endcase
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_lo_q   <= 8'd0;
            n_q        <= 16'd0;
            byte_idx_q <= 2'd0;
            word_idx_q <= 16'd0;
            word_buf_q <= 24'd0;
            we_q       <= 1'b0;
            waddr_q    <= 32'd0;
            wdata_q    <= 32'd0;
            loaded_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            n_q        <= n_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            word_buf_q <= word_buf_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            loaded_q   <= loaded_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Summary  : Directed/random bench for imem_loader with a stream-level model.
// Revision : 1.0
// ============================================================================
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a, start_b;
    logic [7:0]  inData;
    logic        inValid;

    logic        a_rdy, a_we, a_busy, a_done, a_err, a_cpu;
    logic [31:0] a_addr, a_data;
    logic [15:0] a_cnt;
    logic        b_rdy, b_we, b_busy, b_done, b_err, b_cpu;
    logic [31:0] b_addr, b_data;
    logic [15:0] b_cnt;

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start_a), .inData(inData), .inValid(inValid),
        .inReady(a_rdy), .writeEnable(a_we), .writeAddress(a_addr), .writeData(a_data),
        .wordsLoaded(a_cnt), .busy(a_busy), .done(a_done), .error(a_err), .cpuReset(a_cpu)
    );

    imem_loader #(.MAX_WORDS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start_b), .inData(inData), .inValid(inValid),
        .inReady(b_rdy), .writeEnable(b_we), .writeAddress(b_addr), .writeData(b_data),
        .wordsLoaded(b_cnt), .busy(b_busy), .done(b_done), .error(b_err), .cpuReset(b_cpu)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef logic [7:0] bq_t[$];

    wr_t wq_a[$];
    wr_t wq_b[$];
    int  n_cmp = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    int  done_cyc = 0;
    int  we_cyc = 0;
    int  ready_drops = 0;
    bit  data_phase = 1'b0;
    bit  done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_we === 1'b1) begin
            wq_a.push_back('{addr: a_addr, data: a_data});
            we_cyc = cyc;
        end
        if (b_we === 1'b1) wq_b.push_back('{addr: b_addr, data: b_data});
        if (start_a === 1'b1) start_cyc = cyc;
        if (a_done === 1'b1 && !done_prev) done_cyc = cyc;
        done_prev = (a_done === 1'b1);
        if (data_phase && a_rdy !== 1'b1) ready_drops++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Reference: word i is bytes 4i..4i+3, little-endian, at byte address 4i.
    function automatic logic [31:0] ref_word(input bq_t b, input int i);
        return {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
    endfunction

    task automatic pulse_start(input bit isb);
        inValid = 1'b0;
        if (isb) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send(input logic [7:0] v, input int maxgap, input bit isb);
        int g;
        int k;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        if (g > 0) begin
            inValid = 1'b0;
            repeat (g) tick();
        end
        inValid = 1'b1;
        inData  = v;
        k = 0;
        while (((isb ? b_rdy : a_rdy) !== 1'b1) && (k < 20)) begin
            tick();
            k++;
        end
        if (k >= 20) check("accept_timeout", {31'd0, (isb ? b_rdy : a_rdy)}, 32'd1);
        else tick();
    endtask

    task automatic run_load(input bit isb, input logic [15:0] n, input bq_t bytes,
                            input int maxgap, input int mid_start);
        pulse_start(isb);
        send(n[7:0], 0, isb);
        send(n[15:8], 0, isb);
        if (!isb && maxgap > 0) data_phase = 1'b1;
        for (int i = 0; i < bytes.size(); i++) begin
            send(bytes[i], maxgap, isb);
            if (i == mid_start) begin
                inValid = 1'b0;
                start_a = 1'b1;
                tick();
                start_a = 1'b0;
            end
        end
        data_phase = 1'b0;
        inValid    = 1'b0;
    endtask

    task automatic wait_done(input bit isb);
        int k;
        k = 0;
        while (((isb ? b_done : a_done) !== 1'b1) && (k < 10)) begin
            tick();
            k++;
        end
    endtask

    task automatic check_writes(input string tag, input bit isb, input int base,
                                input bq_t bytes, input int n);
        wr_t q[$];
        if (isb) q = wq_b; else q = wq_a;
        check({tag, "_count"}, q.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < q.size()) begin
                check({tag, "_addr"}, q[base+i].addr, 4 * i);
                check({tag, "_data"}, q[base+i].data, ref_word(bytes, i));
            end
        end
    endtask

    initial begin
        bq_t prog;
        bq_t empty;
        bq_t rnd;
        int  base;

        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; inValid = 1'b0; inData = 8'h00;
        repeat (3) tick();
        check("rst_inReady", a_rdy, 0);
        check("rst_we", a_we, 0);
        check("rst_addr", a_addr, 0);
        check("rst_data", a_data, 0);
        check("rst_loaded", a_cnt, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_error", a_err, 0);
        check("rst_cpuReset", a_cpu, 1);
        reset = 1'b0;
        tick();

        // N=3, no gaps
        prog = '{8'h13, 8'h04, 8'h30, 8'h00, 8'h93, 8'h04, 8'h10, 8'h00,
                 8'h13, 8'h09, 8'h00, 8'h01};
        base = wq_a.size();
        run_load(1'b0, 16'd3, prog, 0, -1);
        check("t1_flush_we", a_we, 1);
        check("t1_flush_cpuReset", a_cpu, 1);
        check("t1_flush_done", a_done, 0);
        tick();
        check("t1_done", a_done, 1);
        check("t1_cpuReset", a_cpu, 0);
        check("t1_busy", a_busy, 0);
        check("t1_loaded", a_cnt, 3);
        tick();
        check("t1_latency", done_cyc - start_cyc, 4 * 3 + 4);
        check("t1_done_after_we", done_cyc - we_cyc, 1);
        check_writes("t1", 1'b0, base, prog, 3);
        if (wq_a.size() > base) check("t1_word0_const", wq_a[base].data, 32'h00300413);

        // Same stream with random gaps; inReady must stay high in DATA
        base = wq_a.size();
        run_load(1'b0, 16'd3, prog, 3, -1);
        wait_done(1'b0);
        check("t2_done", a_done, 1);
        check("t2_ready_in_data", ready_drops, 0);
        check("t2_loaded", a_cnt, 3);
        check_writes("t2", 1'b0, base, prog, 3);

        // Zero length rejected, then N=1 recovers
        base = wq_a.size();
        run_load(1'b0, 16'd0, empty, 0, -1);
        check("t3_error", a_err, 1);
        check("t3_inReady", a_rdy, 0);
        check("t3_cpuReset", a_cpu, 1);
        check("t3_loaded", a_cnt, 0);
        tick();
        check("t3_no_writes", wq_a.size() - base, 0);
        prog = '{8'hb3, 8'h62, 8'h94, 8'h00};
        base = wq_a.size();
        run_load(1'b0, 16'd1, prog, 0, -1);
        wait_done(1'b0);
        check("t3_done", a_done, 1);
        check("t3_error_cleared", a_err, 0);
        check("t3_loaded1", a_cnt, 1);
        check_writes("t3", 1'b0, base, prog, 1);
        if (wq_a.size() > base) check("t3_word_const", wq_a[base].data, 32'h009462b3);

        // MAX_WORDS=4: N=5 rejected, N=4 accepted
        base = wq_b.size();
        run_load(1'b1, 16'd5, empty, 0, -1);
        check("t4_error", b_err, 1);
        check("t4_inReady", b_rdy, 0);
        check("t4_cpuReset", b_cpu, 1);
        tick();
        check("t4_no_writes", wq_b.size() - base, 0);
        rnd  = rand_bytes(16);
        base = wq_b.size();
        run_load(1'b1, 16'd4, rnd, 1, -1);
        wait_done(1'b1);
        check("t4_max_done", b_done, 1);
        check("t4_max_loaded", b_cnt, 4);
        check_writes("t4", 1'b1, base, rnd, 4);

        // start pulsed during DATA is ignored
        rnd  = rand_bytes(20);
        base = wq_a.size();
        run_load(1'b0, 16'd5, rnd, 2, 6);
        wait_done(1'b0);
        check("t5_done", a_done, 1);
        check("t5_loaded", a_cnt, 5);
        check_writes("t5", 1'b0, base, rnd, 5);

        // Asynchronous reset mid-load after 6 data bytes
        rnd  = rand_bytes(8);
        base = wq_a.size();
        pulse_start(1'b0);
        send(8'h02, 0, 1'b0);
        send(8'h00, 0, 1'b0);
        for (int i = 0; i < 6; i++) send(rnd[i], 0, 1'b0);
        check("t6_one_write", wq_a.size() - base, 1);
        if (wq_a.size() > base) begin
            check("t6_addr", wq_a[base].addr, 0);
            check("t6_data", wq_a[base].data, ref_word(rnd, 0));
        end
        #3 reset = 1'b1;
        #1;
        check("t6_rst_inReady", a_rdy, 0);
        check("t6_rst_we", a_we, 0);
        check("t6_rst_addr", a_addr, 0);
        check("t6_rst_data", a_data, 0);
        check("t6_rst_loaded", a_cnt, 0);
        check("t6_rst_busy", a_busy, 0);
        check("t6_rst_cpuReset", a_cpu, 1);
        repeat (3) tick();
        #3 reset = 1'b0;
        inData = 8'hAA;
        repeat (4) tick();
        check("t6_post_inReady", a_rdy, 0);
        check("t6_post_busy", a_busy, 0);
        check("t6_post_done", a_done, 0);
        check("t6_post_cpuReset", a_cpu, 1);
        check("t6_post_writes", wq_a.size() - base, 1);
        inValid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
